// File: rtl/kpg_iter_adder.sv
// Iterative K/P/G prefix adder: encodes operands into kill/propagate/generate codes,
// resolves one prefix level per clock, then decodes sum, carry-out and signed overflow.
module kpg_iter_adder #(
  parameter int WIDTH  = 64,
  parameter int LEVELS = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int IDX_W = $clog2(WIDTH);

  localparam logic [1:0] KPG_K = 2'b00;
  localparam logic [1:0] KPG_P = 2'b01;
  localparam logic [1:0] KPG_G = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_PREFIX, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic [LVL_W-1:0]        lvl_q, lvl_d;
  logic [WIDTH-1:0][1:0]   kpg_q, kpg_d;
  logic [WIDTH-1:0][1:0]   kpg_lvl;
  logic [WIDTH-1:0]        carry;
  logic [WIDTH-1:0]        a_q, a_d, b_q, b_d;
  logic                    cin_q, cin_d;
  logic [WIDTH-1:0]        sum_q, sum_d;
  logic                    cout_q, cout_d;
  logic                    ovf_q, ovf_d;
  logic                    last_lvl;
  int                      span;

  assign last_lvl = (lvl_q == LVL_W'(LEVELS - 1));

  // One prefix level: a P position inherits the code 'span' positions below it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    kpg_lvl = kpg_q;
    carry   = '0;
    span    = 32'd1 << lvl_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (i >= span && kpg_q[i] == KPG_P) begin
        kpg_lvl[i] = kpg_q[IDX_W'(i - span)];
      end
    end
    for (int i = 0; i < WIDTH; i++) begin
      carry[i] = (kpg_lvl[i] == KPG_G);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (in_valid)  state_d = S_PREFIX;
      S_PREFIX: if (last_lvl)  state_d = S_DONE;
      S_DONE:   if (out_ready) state_d = S_IDLE;
      default:                 state_d = S_IDLE;
    endcase
  end

  always_comb begin
    lvl_d  = lvl_q;
    kpg_d  = kpg_q;
    a_d    = a_q;
    b_d    = b_q;
    cin_d  = cin_q;
    sum_d  = sum_q;
    cout_d = cout_q;
    ovf_d  = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d   = a;
          b_d   = b;
          cin_d = cin;
          lvl_d = '0;
          for (int i = 0; i < WIDTH; i++) begin
            if (a[i] ^ b[i])      kpg_d[i] = KPG_P;
            else if (a[i] & b[i]) kpg_d[i] = KPG_G;
            else                  kpg_d[i] = KPG_K;
          end
          // Carry-in resolves position 0 immediately, so it never stays P.
          if (a[0] ^ b[0]) kpg_d[0] = cin ? KPG_G : KPG_K;
        end
      end
      S_PREFIX: begin
        kpg_d = kpg_lvl;
        lvl_d = last_lvl ? '0 : lvl_q + 1'b1;
        if (last_lvl) begin
          sum_d  = a_q ^ b_q ^ {carry[WIDTH-2:0], cin_q};
          cout_d = carry[WIDTH-1];
          ovf_d  = carry[WIDTH-1] ^ carry[WIDTH-2];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    sum       = sum_q;
    cout      = cout_q;
    ovf       = ovf_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so all flops sample together.
    if (rst) begin
      state_q <= S_IDLE;
      lvl_q   <= '0;
      kpg_q   <= '{default: KPG_K};
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      kpg_q   <= kpg_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
